// File: rtl/cp0_timer_ctrl.sv
// cp0_timer_ctrl: CP0 Count/Compare timer pair.
// Count advances once every COUNT_DIV enabled clocks. Compare is loaded by mtc0.
// A tick that carries Count onto Compare sets a sticky timer interrupt.
// A later Compare write clears that interrupt.
// The reset input is named rst_n but is active-high (1 = reset).
module cp0_timer_ctrl #(
  parameter int unsigned COUNT_DIV    = 2,
  parameter logic [31:0] COMPARE_INI  = 32'h0000_0000,
  parameter logic [7:0]  ADDR_COUNT   = 8'h48,
  parameter logic [7:0]  ADDR_COMPARE = 8'h58
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_en,
  input  logic        mtc0_we,
  input  logic [31:0] mtc0_data,
  input  logic [7:0]  cp0_addr,
  output logic [31:0] cp0_Count_data,
  output logic [31:0] cp0_Compare_data,
  output logic [31:0] cp0_rdata,
  output logic        timer_int
);

  localparam int unsigned DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      compare_q, compare_d;
  logic             timer_int_q, timer_int_d;

  logic             tick_s;
  logic             wr_count_s;
  logic             wr_compare_s;
  logic [31:0]      count_inc_s;

  // Decode mtc0 targets and the divided increment strobe.
  always_comb begin
    wr_count_s   = mtc0_we && (cp0_addr == ADDR_COUNT);
    wr_compare_s = mtc0_we && (cp0_addr == ADDR_COMPARE);
    tick_s       = count_en && (div_cnt_q == DIV_LAST);
    count_inc_s  = count_q + 32'd1;
  end

  // Next-state logic: a Count write wins over a tick, and a Compare write wins over a match.
  always_comb begin
    div_cnt_d   = div_cnt_q;
    count_d     = count_q;
    compare_d   = compare_q;
    timer_int_d = timer_int_q;

    // Divider: a Count write restarts the phase, so the first increment is a full period later.
    if (wr_count_s) begin
      div_cnt_d = {DIV_W{1'b0}};
    end else if (!count_en) begin
      div_cnt_d = div_cnt_q;
    end else if (tick_s) begin
      div_cnt_d = {DIV_W{1'b0}};
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    // Count: a written value replaces any tick that lands on the same edge.
    if (wr_count_s) begin
      count_d = mtc0_data;
    end else if (tick_s) begin
      count_d = count_inc_s;
    end else begin
      count_d = count_q;
    end

    if (wr_compare_s) begin
      compare_d = mtc0_data;
    end else begin
      compare_d = compare_q;
    end

    // Only a real increment onto Compare raises the interrupt. A Count write never does.
    if (wr_compare_s) begin
      timer_int_d = 1'b0;
    end else if (tick_s && !wr_count_s && (count_inc_s == compare_q)) begin
      timer_int_d = 1'b1;
    end else begin
      timer_int_d = timer_int_q;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      div_cnt_q   <= {DIV_W{1'b0}};
      count_q     <= 32'h0000_0000;
      compare_q   <= COMPARE_INI;
      timer_int_q <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      timer_int_q <= timer_int_d;
    end
  end

  // Combinational mfc0 read mux over the current register values.
  always_comb begin
    cp0_rdata = 32'h0000_0000;
    case (cp0_addr)
      ADDR_COUNT:   cp0_rdata = count_q;
      ADDR_COMPARE: cp0_rdata = compare_q;
      default:      cp0_rdata = 32'h0000_0000;
    endcase
  end

  assign cp0_Count_data   = count_q;
  assign cp0_Compare_data = compare_q;
  assign timer_int        = timer_int_q;

endmodule

// File: tb/tb_cp0_timer_ctrl.sv
// Testbench for cp0_timer_ctrl.
// A directed vector table covers the timer scenarios and their corner cases.
// Hand-written sequences cover the read mux and asynchronous reset.
// A randomized run is checked against a cycle-level behavioural model.
module tb_cp0_timer_ctrl;

  localparam int unsigned DIV = 2;
  localparam logic [7:0] A_CNT = 8'h48;
  localparam logic [7:0] A_CMP = 8'h58;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        count_en;
  logic        mtc0_we;
  logic [31:0] mtc0_data;
  logic [7:0]  cp0_addr;
  logic [31:0] cp0_Count_data;
  logic [31:0] cp0_Compare_data;
  logic [31:0] cp0_rdata;
  logic        timer_int;

  int n_checks = 0;
  int n_pass   = 0;

  cp0_timer_ctrl #(
    .COUNT_DIV   (DIV),
    .COMPARE_INI (32'h0000_0000),
    .ADDR_COUNT  (A_CNT),
    .ADDR_COMPARE(A_CMP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .count_en        (count_en),
    .mtc0_we         (mtc0_we),
    .mtc0_data       (mtc0_data),
    .cp0_addr        (cp0_addr),
    .cp0_Count_data  (cp0_Count_data),
    .cp0_Compare_data(cp0_Compare_data),
    .cp0_rdata       (cp0_rdata),
    .timer_int       (timer_int)
  );

  always #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: time limit expired before summary");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        en;
    logic [31:0] ec;
    logic [31:0] ecmp;
    logic        eint;
  } vec_t;

  vec_t vq[$];

  // Behavioural reference: enabled-cycle count since the last Count write or reset.
  int unsigned m_en_cyc;
  logic [31:0] m_count;
  logic [31:0] m_compare;
  logic        m_int;

  function automatic void add(logic we, logic [7:0] addr, logic [31:0] data, logic en,
                              logic [31:0] ec, logic [31:0] ecmp, logic eint);
    vec_t v;
    v = '{we, addr, data, en, ec, ecmp, eint};
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_en_cyc  = 0;
    m_count   = 32'h0;
    m_compare = 32'h0;
    m_int     = 1'b0;
  endtask

  task automatic model_edge(input logic we, input logic [7:0] addr, input logic [31:0] data,
                            input logic en);
    bit tick;
    bit wc;
    bit wp;
    logic [31:0] nxt;
    tick = en && ((m_en_cyc % DIV) == (DIV - 1));
    wc   = we && (addr == A_CNT);
    wp   = we && (addr == A_CMP);
    nxt  = m_count + 32'd1;
    if (en) m_en_cyc++;
    if (wc) begin
      m_count  = data;
      m_en_cyc = 0;
    end else if (tick) begin
      if (nxt == m_compare) m_int = 1'b1;
      m_count = nxt;
    end
    if (wp) begin
      m_compare = data;
      m_int     = 1'b0;
    end
  endtask

  task automatic drive(input logic we, input logic [7:0] addr, input logic [31:0] data,
                       input logic en);
    mtc0_we   = we;
    cp0_addr  = addr;
    mtc0_data = data;
    count_en  = en;
  endtask

  // Reset is asserted just after a posedge and released just after a later posedge.
  task automatic do_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  a;
    logic [31:0] exp_rd;
    int          r;

    drive(1'b0, 8'h00, 32'h0, 1'b0);
    rst_n = 1'b0;
    #2;
    do_reset();

    chk("reset_count", cp0_Count_data, 32'h0);
    chk("reset_compare", cp0_Compare_data, 32'h0);
    chk("reset_int", {31'b0, timer_int}, 32'h0);

    // Scenario 1: ten enabled cycles give Count = 5.
    for (int k = 1; k <= 10; k++) add(1'b0, 8'h00, 32'hDEADBEEF, 1'b1, 32'(k / 2), 32'h0, 1'b0);
    // Scenario 2: Compare = 8, Count = 0, the interrupt rises when Count reaches 8 and then stays set.
    add(1'b1, A_CMP, 32'd8, 1'b1, 32'd5, 32'd8, 1'b0);
    add(1'b1, A_CNT, 32'd0, 1'b1, 32'd0, 32'd8, 1'b0);
    for (int k = 1; k <= 20; k++) add(1'b0, 8'h00, 32'h0, 1'b1, 32'(k / 2), 32'd8, (k >= 16));
    // Scenario 3: a Compare write clears the interrupt while Count keeps running.
    add(1'b1, A_CMP, 32'h100, 1'b1, 32'd10, 32'h100, 1'b0);
    add(1'b0, 8'h00, 32'h0, 1'b1, 32'd11, 32'h100, 1'b0);
    add(1'b0, 8'h00, 32'h0, 1'b1, 32'd11, 32'h100, 1'b0);
    add(1'b0, 8'h00, 32'h0, 1'b1, 32'd12, 32'h100, 1'b0);
    // Scenario 4: Count wraps from FFFFFFFF onto Compare = 0 and raises the interrupt.
    add(1'b1, A_CNT, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'h100, 1'b0);
    add(1'b1, A_CMP, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0);
    add(1'b0, 8'h00, 32'h0, 1'b1, 32'h0, 32'h0, 1'b1);
    add(1'b0, 8'h00, 32'h0, 1'b1, 32'h0, 32'h0, 1'b1);
    add(1'b0, 8'h00, 32'h0, 1'b1, 32'd1, 32'h0, 1'b1);
    // Scenario 5: a Count write equal to Compare does not interrupt; clear wins over a match.
    add(1'b1, A_CMP, 32'd20, 1'b1, 32'd1, 32'd20, 1'b0);
    add(1'b1, A_CNT, 32'd20, 1'b1, 32'd20, 32'd20, 1'b0);
    add(1'b0, 8'h00, 32'h0, 1'b1, 32'd20, 32'd20, 1'b0);
    add(1'b0, 8'h00, 32'h0, 1'b1, 32'd21, 32'd20, 1'b0);
    add(1'b0, 8'h00, 32'h0, 1'b1, 32'd21, 32'd20, 1'b0);
    add(1'b0, 8'h00, 32'h0, 1'b1, 32'd22, 32'd20, 1'b0);
    add(1'b1, A_CNT, 32'd19, 1'b1, 32'd19, 32'd20, 1'b0);
    add(1'b0, 8'h00, 32'h0, 1'b1, 32'd19, 32'd20, 1'b0);
    add(1'b1, A_CMP, 32'h100, 1'b1, 32'd20, 32'h100, 1'b0);
    add(1'b0, 8'h00, 32'h0, 1'b1, 32'd20, 32'h100, 1'b0);
    // Scenario 6: count_en = 0 freezes Count and the divider phase.
    for (int k = 0; k < 6; k++) add(1'b0, 8'h00, 32'h0, 1'b0, 32'd20, 32'h100, 1'b0);
    add(1'b0, 8'h00, 32'h0, 1'b1, 32'd21, 32'h100, 1'b0);
    // A write with count_en = 0 still lands; a write to another address changes nothing.
    add(1'b1, A_CNT, 32'd5, 1'b0, 32'd5, 32'h100, 1'b0);
    add(1'b0, 8'h00, 32'h0, 1'b1, 32'd5, 32'h100, 1'b0);
    add(1'b0, 8'h00, 32'h0, 1'b1, 32'd6, 32'h100, 1'b0);
    add(1'b1, 8'h60, 32'd123, 1'b1, 32'd6, 32'h100, 1'b0);
    add(1'b0, 8'h00, 32'h0, 1'b1, 32'd7, 32'h100, 1'b0);

    foreach (vq[i]) begin
      drive(vq[i].we, vq[i].addr, vq[i].data, vq[i].en);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_count", i), cp0_Count_data, vq[i].ec);
      chk($sformatf("vec%0d_compare", i), cp0_Compare_data, vq[i].ecmp);
      chk($sformatf("vec%0d_int", i), {31'b0, timer_int}, {31'b0, vq[i].eint});
    end

    // Read mux: Count = 7 and Compare = 0x100 here.
    drive(1'b0, A_CNT, 32'h0, 1'b0);
    #1 chk("rdata_count", cp0_rdata, 32'd7);
    cp0_addr = A_CMP;
    #1 chk("rdata_compare", cp0_rdata, 32'h100);
    cp0_addr = 8'h49;
    #1 chk("rdata_other", cp0_rdata, 32'h0);

    // Asynchronous reset between edges while the interrupt is set.
    do_reset();
    drive(1'b1, A_CMP, 32'd2, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 32'h0, 1'b1);
    repeat (4) @(posedge clk);
    #1 chk("pre_async_int", {31'b0, timer_int}, 32'h1);
    #3 rst_n = 1'b1;
    #1;
    chk("async_count", cp0_Count_data, 32'h0);
    chk("async_compare", cp0_Compare_data, 32'h0);
    chk("async_int", {31'b0, timer_int}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();

    // Randomized run against the reference model.
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 99));
      case ($urandom_range(0, 2))
        0:       d = $urandom();
        1:       d = m_count + 32'($urandom_range(0, 6));
        default: d = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      endcase
      case ($urandom_range(0, 3))
        0:       a = A_CNT;
        1:       a = A_CMP;
        2:       a = 8'($urandom_range(0, 255));
        default: a = 8'h00;
      endcase
      drive((r < 8), a, d, ($urandom_range(0, 9) != 0));
      #1;
      exp_rd = (a == A_CNT) ? m_count : ((a == A_CMP) ? m_compare : 32'h0);
      chk("rand_rdata", cp0_rdata, exp_rd);
      @(posedge clk);
      model_edge(mtc0_we, cp0_addr, mtc0_data, count_en);
      #1;
      chk("rand_count", cp0_Count_data, m_count);
      chk("rand_compare", cp0_Compare_data, m_compare);
      chk("rand_int", {31'b0, timer_int}, {31'b0, m_int});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
